aes_decrypt_iter: RTL and testbench

Iterative AES-128 decryption core, one round per clock. It is the inverse counterpart of the team's unrolled combinational AES-128 encryption datapath. Ciphertext and cipher key enter through a valid/ready handshake; plaintext leaves through a valid/ready handshake. Round keys are generated on the fly: forward expansion to round key 10, then inverse expansion while decrypting, so no 11-entry key schedule RAM is needed.

---
 rtl/aes_decrypt_iter.sv | 218 +++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption: one round per clock, valid/ready on both sides.
// Round keys are expanded forward to k10, then unwound in step with the rounds.
module aes_decrypt_iter #(
  parameter int KEY_REUSE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] p_data
);

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, DONE} state_t;

  // Tables are stored MSB-first, so entry x lives at index ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] x);
    return INV_SBOX[~x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: recover the previous w3 first, since SubWord needs it.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = isb(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a  = col[31-8*i -: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t       state;
  logic [127:0] st, rk, key_q;
  logic [3:0]   rnd;
  logic         cache_vld;
  logic [127:0] cache_key, cache_k10;

  logic [127:0] rk_fwd, rk_inv, st_sub, st_mix;
  logic         hit;

  always_comb begin
    rk_fwd = key_fwd(rk, rcon(rnd));
    rk_inv = key_inv(rk, rcon(rnd));
    st_sub = inv_shift_sub(st) ^ rk;
    st_mix = '0;
    for (int c = 0; c < 4; c++) begin
      st_mix[127-32*c -: 32] = inv_mix_col(st_sub[127-32*c -: 32]);
    end
    hit = (KEY_REUSE != 0) && cache_vld && (key == cache_key);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p_data    <= '0;
      st        <= '0;
      rk        <= '0;
      key_q     <= '0;
      rnd       <= '0;
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_k10 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            st       <= data;
            key_q    <= key;
            if (hit) begin
              rk    <= cache_k10;
              rnd   <= 4'd10;
              state <= ADDK;
            end else begin
              rk    <= key;
              rnd   <= 4'd1;
              state <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          rk <= rk_fwd;
          if (rnd == 4'd10) begin
            cache_vld <= 1'b1;
            cache_key <= key_q;
            cache_k10 <= rk_fwd;
            state     <= ADDK;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ADDK: begin
          st    <= st ^ rk;
          rk    <= rk_inv;
          rnd   <= 4'd9;
          state <= ROUND;
        end
        ROUND: begin
          if (rnd != 4'd0) begin
            st  <= st_mix;
            rk  <= rk_inv;
            rnd <= rnd - 4'd1;
          end else begin
            st        <= st_sub;
            p_data    <= st_sub;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS vectors, key cache latency, backpressure, reset, random round-trip.
module tb_aes_decrypt_iter;

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] data_i = '0;
  logic rdy0, rdy1, ov0, ov1, rdy, ov;
  logic [127:0] pd0, pd1, pd;

  int checks = 0;
  int errors = 0;

  assign rdy = sel ? rdy1 : rdy0;
  assign ov  = sel ? ov1 : ov0;
  assign pd  = sel ? pd1 : pd0;

  aes_decrypt_iter #(.KEY_REUSE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .key(key_i), .data(data_i), .out_valid(ov0), .out_ready(out_ready), .p_data(pd0)
  );

  aes_decrypt_iter #(.KEY_REUSE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy1),
    .key(key_i), .data(data_i), .out_valid(ov1), .out_ready(out_ready), .p_data(pd1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Encryption reference built from GF(2^8) arithmetic, independent of any stored table.
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] y, r, s;
    y = gm(x, x);
    r = y;
    for (int i = 0; i < 6; i++) begin
      y = gm(y, y);
      r = gm(r, y);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk;
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tw, w0, w1, w2, w3;
    rk = k;
    s  = p ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sb_tab[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = b[4*((c+w)%4)+w];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      tw = {sb_tab[rk[23:16]], sb_tab[rk[15:8]], sb_tab[rk[7:0]], sb_tab[rk[31:24]]} ^ {rc, 24'h0};
      w0 = rk[127:96] ^ tw;
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rc = gm(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    end
    return s;
  endfunction

  task automatic start_req(input logic [127:0] k, input logic [127:0] d, input string name);
    int n;
    n = 0;
    while (!rdy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({name, " in_ready before accept"}, 128'(rdy), 128'd1);
    key_i = k;
    data_i = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_i = ~k;
    data_i = ~d;
  endtask

  task automatic wait_out(input int lat, input string name, input bit chk_rk);
    int cnt;
    bit busy_ok;
    cnt = 0;
    busy_ok = 1'b1;
    while (!ov && cnt < 40) begin
      if (rdy) busy_ok = 1'b0;
      @(posedge clk); #1; cnt++;
      if (chk_rk && cnt == 10) chk({name, " rk after keyexp"}, dut0.rk, BK10);
    end
    chk({name, " latency"}, 128'(cnt), 128'(lat));
    chk({name, " in_ready low while busy"}, 128'(busy_ok), 128'd1);
  endtask

  task automatic handshake(input logic [127:0] exp, input string name, input bit rnd_ordy);
    logic [127:0] held;
    bit stable, hs;
    int n;
    held = pd;
    stable = 1'b1;
    hs = 1'b0;
    n = 0;
    chk({name, " p_data"}, pd, exp);
    while (!hs && n < 300) begin
      out_ready = rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      hs = out_ready;
      #1; n++;
      if (!hs && (!ov || pd !== held)) stable = 1'b0;
    end
    out_ready = 1'b1;
    chk({name, " stable during stall"}, 128'(stable), 128'd1);
    chk({name, " handshake done"}, 128'(hs), 128'd1);
    chk({name, " out_valid after handshake"}, 128'(ov), 128'd0);
    chk({name, " in_ready after handshake"}, 128'(rdy), 128'd1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] exp;
    int           lat;
    bit           dut;
    bit           chk_rk;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [127:0] held, k, p, prev_k, mc_key;
    bit ok, mc_vld;
    int lat;

    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

    tbl[0] = '{C1K, C1C, C1P, 21, 1'b0, 1'b0};
    tbl[1] = '{BK,  BC,  BP,  21, 1'b0, 1'b1};
    tbl[2] = '{BK,  BC,  BP,  11, 1'b0, 1'b0};
    tbl[3] = '{C1K, C1C, C1P, 21, 1'b0, 1'b0};
    tbl[4] = '{C1K, C1C, C1P, 11, 1'b0, 1'b0};
    tbl[5] = '{BK,  BC,  BP,  21, 1'b1, 1'b0};
    tbl[6] = '{BK,  BC,  BP,  21, 1'b1, 1'b0};
    tbl[7] = '{C1K, C1C, C1P, 21, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 128'(rdy0), 128'd1);
    chk("reset out_valid", 128'(ov0), 128'd0);
    chk("reset p_data", pd0, 128'd0);
    chk("reset in_ready nocache", 128'(rdy1), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].dut;
      start_req(tbl[i].key, tbl[i].data, $sformatf("vec%0d", i));
      wait_out(tbl[i].lat, $sformatf("vec%0d", i), tbl[i].chk_rk);
      handshake(tbl[i].exp, $sformatf("vec%0d", i), 1'b0);
    end
    sel = 1'b0;

    // Long output stall with in_valid pulses that must be ignored.
    start_req(C1K, C1C, "bp");
    wait_out(11, "bp", 1'b0);
    held = pd;
    ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = i[0];
      key_i = BK;
      data_i = BC;
      @(posedge clk); #1;
      if (!ov || pd !== held || rdy) ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp outputs held", 128'(ok), 128'd1);
    chk("bp p_data", pd, C1P);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out_valid released", 128'(ov), 128'd0);
    chk("bp in_ready released", 128'(rdy), 128'd1);

    // Reset during key expansion must abandon the block and drop the cache.
    start_req(BK, BC, "prerst");
    wait_out(21, "prerst", 1'b0);
    handshake(BP, "prerst", 1'b0);
    start_req(C1K, C1C, "rst");
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", 128'(rdy), 128'd1);
    chk("rst out_valid", 128'(ov), 128'd0);
    chk("rst p_data", pd, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_req(BK, BC, "postrst");
    wait_out(21, "postrst", 1'b0);
    handshake(BP, "postrst", 1'b0);

    // Random round-trip with a reference model of the single-entry cache.
    mc_vld = 1'b1;
    mc_key = BK;
    prev_k = BK;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) k = prev_k;
      else k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      lat = (mc_vld && k == mc_key) ? 11 : 21;
      mc_vld = 1'b1;
      mc_key = k;
      prev_k = k;
      start_req(k, aes_enc(k, p), $sformatf("rnd%0d", n));
      wait_out(lat, $sformatf("rnd%0d", n), 1'b0);
      handshake(p, $sformatf("rnd%0d", n), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
